// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// serializer_pkg : shared state encoding and width helper for the serializer
// Revision       : 1.0 - initial release
// ============================================================================
package serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Smallest n such that 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// fifo_sync : single-clock FIFO, head word visible combinationally on rdata
// Revision  : 1.0 - initial release
// ============================================================================
module fifo_sync
  import serializer_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [D_WIDTH-1:0] wdata,
  output logic [D_WIDTH-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  logic [D_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  // A push on a full FIFO still fits when the head leaves on the same edge.
  assign w_pop_ok  = pop && (r_count != '0);
  assign w_push_ok = push && ((r_count != C_DEPTH) || w_pop_ok);

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// serializer : buffered parallel-to-serial stage, MSB first, first/last strobes
// Revision   : 1.0 - initial release
// ============================================================================
module serializer
  import serializer_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  output logic               data_o,
  output logic               valid_o,
  output logic               first_o,
  output logic               last_o,
  output logic               busy_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               overflow_o
);

  localparam int CNT_W = clog2(D_WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [D_WIDTH-1:0] r_shift;
  logic [D_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_first;
  logic               w_first_nxt;
  logic               r_overflow;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [D_WIDTH-1:0] w_head;

  fifo_sync #(
    .D_WIDTH    (D_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (valid_i),
    .pop   (w_pop),
    .wdata (data_i),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_first    <= w_first_nxt;
      r_overflow <= valid_i && w_full && !w_pop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_cnt_nxt   = CNT_W'(D_WIDTH - 1);
          w_first_nxt = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == '0) begin
          // Reload straight from the FIFO so consecutive words have no gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_cnt_nxt   = CNT_W'(D_WIDTH - 1);
            w_first_nxt = 1'b1;
          end else begin
            w_shift_nxt = {r_shift[D_WIDTH-2:0], 1'b0};
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_shift_nxt = {r_shift[D_WIDTH-2:0], 1'b0};
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign data_o     = r_shift[D_WIDTH-1];
  assign valid_o    = (r_state == ST_SHIFT);
  assign busy_o     = (r_state == ST_SHIFT);
  assign first_o    = r_first;
  assign last_o     = (r_state == ST_SHIFT) && (r_cnt == '0);
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_serializer : table vectors, corner sequences and random traffic vs model
// Revision      : 1.0 - initial release
// ============================================================================
module tb_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i  = '0;
  logic          data_o, valid_o, first_o, last_o, busy_o, full_o, empty_o, overflow_o;

  int total = 0;
  int bad   = 0;

  serializer #(.D_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .first_o    (first_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  // Reference: a word queue plus the index of the bit currently on the line.
  logic [DW-1:0] m_q[$];
  bit            m_active;
  int            m_idx;
  logic [DW-1:0] m_word;
  bit            m_ovf;

  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_words[$];
  logic [DW-1:0] acc;

  typedef struct {
    logic          vin;
    logic [DW-1:0] din;
    logic          ev, ed, ef, el, eb, ee;
  } vec_t;
  vec_t tbl[DW+2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_active = 0;
    m_idx    = 0;
    m_ovf    = 0;
  endfunction

  function automatic void model_edge(input logic v, input logic [DW-1:0] d);
    bit pop_now;
    bit was_full;
    pop_now  = (m_q.size() > 0) && (!m_active || m_idx == DW-1);
    was_full = (m_q.size() == DEPTH);
    if (pop_now) begin
      m_word   = m_q.pop_front();
      m_active = 1;
      m_idx    = 0;
    end else if (m_active) begin
      if (m_idx == DW-1) m_active = 0;
      else m_idx++;
    end
    m_ovf = v && was_full && !pop_now;
    if (v && !m_ovf) m_q.push_back(d);
  endfunction

  task automatic check_model();
    chk("valid_o", valid_o, m_active);
    chk("busy_o", busy_o, m_active);
    chk("first_o", first_o, m_active && m_idx == 0);
    chk("last_o", last_o, m_active && m_idx == DW-1);
    chk("full_o", full_o, m_q.size() == DEPTH);
    chk("empty_o", empty_o, m_q.size() == 0);
    chk("overflow_o", overflow_o, m_ovf);
    if (m_active) chk("data_o", data_o, m_word[DW-1-m_idx]);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d);
    valid_i = v;
    data_i  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    check_model();
    if (valid_o) begin
      acc = {acc[DW-2:0], data_o};
      if (last_o) got.push_back(acc);
    end
  endtask

  task automatic check_words(input string name);
    chk({name, "_count"}, got.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < got.size(); i++)
      chk({name, "_word"}, got[i], exp_words[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] pat;
    int            nvalid;
    int            ndrop;
    logic          prev_v;
    bit            found;
    int            p;

    // Reset held with valid_i toggling.
    model_reset();
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      valid_i = i[0] ? 1'b0 : 1'b1;
      data_i  = DW'($urandom);
      @(posedge clk);
      #1;
      chk("rst_data", data_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_first", first_o, 0);
      chk("rst_last", last_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_full", full_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_ovf", overflow_o, 0);
    end
    valid_i = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0);

    // Single word 8'hA5 from a vector table.
    pat    = 8'hA5;
    tbl[0] = '{1'b1, pat, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= DW; i++)
      tbl[i] = '{1'b0, '0, 1'b1, pat[DW-i], (i == 1), (i == DW), 1'b1, 1'b1};
    tbl[DW+1] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < DW+2; i++) begin
      step(tbl[i].vin, tbl[i].din);
      chk("tbl_valid", valid_o, tbl[i].ev);
      if (tbl[i].ev) chk("tbl_data", data_o, tbl[i].ed);
      chk("tbl_first", first_o, tbl[i].ef);
      chk("tbl_last", last_o, tbl[i].el);
      chk("tbl_busy", busy_o, tbl[i].eb);
      chk("tbl_empty", empty_o, tbl[i].ee);
    end

    // Back-to-back words: 16 contiguous bits.
    got.delete();
    step(1'b1, 8'hFF);
    nvalid = 0;
    ndrop  = 0;
    prev_v = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step(i == 0 ? 1'b1 : 1'b0, '0);
      if (valid_o) nvalid++;
      if (prev_v && !valid_o) ndrop++;
      prev_v = valid_o;
    end
    chk("b2b_bits", nvalid, 16);
    chk("b2b_gaps", ndrop, 1);
    exp_words = '{8'hFF, 8'h00};
    check_words("b2b");

    // Overflow: sixth word dropped.
    got.delete();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, DW'(i));
      if (i == 5) chk("ovf_full", full_o, 1);
      if (i == 6) chk("ovf_pulse", overflow_o, 1);
    end
    step(1'b0, '0);
    chk("ovf_one_cycle", overflow_o, 0);
    for (int i = 0; i < 50; i++) step(1'b0, '0);
    exp_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_words("ovf");

    // Push on full coinciding with the pop of the next word.
    got.delete();
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    step(1'b1, 8'h44);
    step(1'b1, 8'h55);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      if (last_o && full_o) found = 1;
    end
    chk("pof_reach_last", found, 1);
    step(1'b1, 8'h3C);
    chk("pof_no_ovf", overflow_o, 0);
    chk("pof_full", full_o, 1);
    for (int i = 0; i < 60; i++) step(1'b0, '0);
    exp_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h3C};
    check_words("pof");

    // Asynchronous reset pulse in the middle of a word.
    got.delete();
    step(1'b1, 8'hC3);
    step(1'b1, 8'h5A);
    step(1'b1, 8'h96);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("mid_bit4_valid", valid_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_first", first_o, 0);
    chk("mid_rst_last", last_o, 0);
    chk("mid_rst_empty", empty_o, 1);
    chk("mid_rst_full", full_o, 0);
    #1;
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0);
      if (valid_o) nvalid++;
    end
    chk("mid_no_resume", nvalid, 0);

    // Random traffic at light, medium and heavy load.
    for (int ph = 0; ph < 3; ph++) begin
      p = (ph == 0) ? 20 : (ph == 1) ? 60 : 95;
      for (int i = 0; i < 300; i++)
        step(($urandom_range(0, 99) < p) ? 1'b1 : 1'b0, DW'($urandom));
    end
    for (int i = 0; i < 50; i++) step(1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
